// File: rtl/rv_lsu_if.sv
// Request/response and memory-bus bundle for the rv_lsu load/store unit.
// slave: the LSU side; master: core plus memory side (drives requests, spo, ready).
interface rv_lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [3:0]      resp_cause;
  logic [31:0]     a;
  logic [XLEN-1:0] d;
  logic            we;
  logic            rd;
  logic [XLEN-1:0] spo;
  logic            ready;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata,
    output resp_err, resp_cause,
    output a, d, we, rd,
    input  spo, ready
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata,
    input  resp_err, resp_cause,
    input  a, d, we, rd,
    output spo, ready
  );
endinterface

// File: rtl/rv_lsu.sv
// Load/store unit: one request at a time onto the a/d/we/rd/spo/ready bus.
// Ports: clk, rst (async active-low), lsu (rv_lsu_if.slave: req/resp + bus).
module rv_lsu #(
  parameter int XLEN      = 32,
  parameter bit BYTE_SWAP = 1'b1,
  parameter int TIMEOUT   = 0,
  parameter int TW        = 8
) (
  input  logic    clk,
  input  logic    rst,
  rv_lsu_if.slave lsu
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam logic [1:0] FULL = (XLEN == 64) ? 2'd3 : 2'd2;

  typedef enum logic [2:0] {
    IDLE, RD, WR, RMW_RD, RMW_WR
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   cnt, cnt_n;
  logic            op_we, op_we_n;
  logic [1:0]      op_size, op_size_n;
  logic            op_uns, op_uns_n;
  logic [OW-1:0]   op_off, op_off_n;
  logic [XLEN-1:0] op_wdata, op_wdata_n;
  logic [31:0]     a_q, a_n;
  logic [XLEN-1:0] d_q, d_n;
  logic            rd_q, rd_n;
  logic            we_q, we_n;
  logic            rv_q, rv_n;
  logic [XLEN-1:0] rdata_q, rdata_n;
  logic            err_q, err_n;
  logic [3:0]      cause_q, cause_n;
  logic [XLEN-1:0] rw;
  logic            mis, ill, expire;

  function automatic logic [XLEN-1:0] bswap(
    input logic [XLEN-1:0] x
  );
    logic [XLEN-1:0] y;
    y = x;
    if (BYTE_SWAP) begin
      for (int i = 0; i < NB; i++)
        y[8*i +: 8] = x[XLEN-8-8*i +: 8];
    end
    return y;
  endfunction

  // Field is shifted down to bit 0, then extended in a
  // 64-bit temporary so no zero-width replication appears.
  function automatic logic [XLEN-1:0] extract(
    input logic [XLEN-1:0] w,
    input logic [1:0]      sz,
    input logic            u,
    input logic [OW-1:0]   off
  );
    logic [XLEN-1:0] sh;
    logic [63:0]     v;
    sh = w >> {off, 3'b000};
    case (sz)
      2'd0: v = u ? {56'b0, sh[7:0]}
                  : {{56{sh[7]}}, sh[7:0]};
      2'd1: v = u ? {48'b0, sh[15:0]}
                  : {{48{sh[15]}}, sh[15:0]};
      2'd2: v = u ? {32'b0, sh[31:0]}
                  : {{32{sh[31]}}, sh[31:0]};
      default: v = 64'(sh);
    endcase
    return v[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] merge(
    input logic [XLEN-1:0] w,
    input logic [XLEN-1:0] wd,
    input logic [1:0]      sz,
    input logic [OW-1:0]   off
  );
    logic [XLEN-1:0] ws, y;
    logic [7:0]      m;
    logic [NB-1:0]   be;
    ws = wd << {off, 3'b000};
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    be = NB'(m) << off;
    for (int i = 0; i < NB; i++)
      y[8*i +: 8] = be[i] ? ws[8*i +: 8] : w[8*i +: 8];
    return y;
  endfunction

  assign rw     = bswap(lsu.spo);
  assign expire = (TIMEOUT != 0) &&
                  (cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    op_we_n    = op_we;
    op_size_n  = op_size;
    op_uns_n   = op_uns;
    op_off_n   = op_off;
    op_wdata_n = op_wdata;
    a_n        = a_q;
    d_n        = d_q;
    rv_n       = 1'b0;
    rdata_n    = '0;
    err_n      = 1'b0;
    cause_n    = 4'd0;
    mis        = 1'b0;
    ill        = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu.req_valid) begin
          op_we_n    = lsu.req_we;
          op_size_n  = lsu.req_size;
          op_uns_n   = lsu.req_unsigned;
          op_off_n   = lsu.req_addr[OW-1:0];
          op_wdata_n = lsu.req_wdata;
          cnt_n      = '0;
          ill = (lsu.req_size == 2'd3) && (XLEN == 32);
          case (lsu.req_size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lsu.req_addr[0];
            2'd2:    mis = |lsu.req_addr[1:0];
            default: mis = |lsu.req_addr[2:0];
          endcase
          if (ill) begin
            rv_n    = 1'b1;
            err_n   = 1'b1;
            cause_n = 4'd2;
          end else if (mis) begin
            rv_n    = 1'b1;
            err_n   = 1'b1;
            cause_n = lsu.req_we ? 4'd6 : 4'd4;
          end else begin
            a_n = {lsu.req_addr[31:OW], {OW{1'b0}}};
            if (!lsu.req_we) begin
              state_n = RD;
            end else if (lsu.req_size == FULL) begin
              state_n = WR;
              d_n     = bswap(lsu.req_wdata);
            end else begin
              state_n = RMW_RD;
            end
          end
        end
      end
      RD, RMW_RD: begin
        if (lsu.ready) begin
          cnt_n = '0;
          if (state == RD) begin
            state_n = IDLE;
            rv_n    = 1'b1;
            rdata_n = extract(rw, op_size,
                              op_uns, op_off);
          end else begin
            state_n = RMW_WR;
            d_n = bswap(merge(rw, op_wdata,
                              op_size, op_off));
          end
        end else if (expire) begin
          state_n = IDLE;
          rv_n    = 1'b1;
          err_n   = 1'b1;
          cause_n = op_we ? 4'd7 : 4'd5;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      WR, RMW_WR: begin
        if (lsu.ready) begin
          state_n = IDLE;
          rv_n    = 1'b1;
        end else if (expire) begin
          state_n = IDLE;
          rv_n    = 1'b1;
          err_n   = 1'b1;
          cause_n = 4'd7;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    rd_n = (state_n == RD) || (state_n == RMW_RD);
    we_n = (state_n == WR) || (state_n == RMW_WR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_we    <= 1'b0;
      op_size  <= 2'd0;
      op_uns   <= 1'b0;
      op_off   <= '0;
      op_wdata <= '0;
      a_q      <= '0;
      d_q      <= '0;
      rd_q     <= 1'b0;
      we_q     <= 1'b0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cause_q  <= 4'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      op_we    <= op_we_n;
      op_size  <= op_size_n;
      op_uns   <= op_uns_n;
      op_off   <= op_off_n;
      op_wdata <= op_wdata_n;
      a_q      <= a_n;
      d_q      <= d_n;
      rd_q     <= rd_n;
      we_q     <= we_n;
      rv_q     <= rv_n;
      rdata_q  <= rdata_n;
      err_q    <= err_n;
      cause_q  <= cause_n;
    end
  end

  assign lsu.req_ready  = (state == IDLE);
  assign lsu.a          = a_q;
  assign lsu.d          = d_q;
  assign lsu.rd         = rd_q;
  assign lsu.we         = we_q;
  assign lsu.resp_valid = rv_q;
  assign lsu.resp_rdata = rdata_q;
  assign lsu.resp_err   = err_q;
  assign lsu.resp_cause = cause_q;
endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: unit A (no swap, timeout 4), unit B (swap).
// Stimulus pushes expected responses; monitors pop on resp_valid.
module tb_rv_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_lsu_if #(.XLEN(32)) ia ();
  rv_lsu_if #(.XLEN(32)) ib ();

  rv_lsu #(.XLEN(32), .BYTE_SWAP(1'b0),
           .TIMEOUT(4), .TW(8))
  dut_a (.clk(clk), .rst(rst), .lsu(ia));

  rv_lsu #(.XLEN(32), .BYTE_SWAP(1'b1),
           .TIMEOUT(0), .TW(8))
  dut_b (.clk(clk), .rst(rst), .lsu(ib));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  cause;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // bus model for unit A
  logic [31:0] spo_a = 32'h0;
  int rd_wait = 0, wr_wait = 0, pc = 0;
  logic pk = 1'b0;
  logic [31:0] pa, pd;
  int rd_cyc = 0, wr_cyc = 0;
  logic [31:0] rd_a = 0, wr_a = 0, wr_d = 0;
  bit both_hi = 0, unstable = 0;
  assign ia.spo = spo_a;

  initial ia.ready = 1'b0;
  always @(negedge clk) begin
    logic k;
    if (ia.rd === 1'b1 && ia.we === 1'b1) both_hi = 1;
    if (ia.rd === 1'b1 || ia.we === 1'b1) begin
      k = ia.we;
      if (pc != 0 && k != pk) pc = 0;
      if (pc != 0 && (ia.a !== pa || ia.d !== pd))
        unstable = 1;
      ia.ready = (pc >= (k ? wr_wait : rd_wait));
      pc++;
      pk = k;
      pa = ia.a;
      pd = ia.d;
      if (k) begin
        wr_cyc++;
        wr_a = ia.a;
        wr_d = ia.d;
      end else begin
        rd_cyc++;
        rd_a = ia.a;
      end
    end else begin
      pc = 0;
      ia.ready = 1'b0;
    end
  end

  // bus model for unit B: always ready
  logic [31:0] spo_b = 32'h0;
  logic [31:0] wr_d_b = 0;
  assign ib.spo   = spo_b;
  assign ib.ready = 1'b1;
  always @(negedge clk)
    if (ib.we === 1'b1) wr_d_b = ib.d;

  always @(negedge clk) begin
    exp_t x;
    if (ia.resp_valid === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL resp_a_unexpected: cause=%0d at cyc %0d, required no response",
                 ia.resp_cause, cyc);
      end else begin
        x = qa.pop_front();
        if (ia.resp_rdata !== x.rdata || ia.resp_err !== x.err ||
            ia.resp_cause !== x.cause || cyc != x.cyc) begin
          errors++;
          $display("FAIL resp_a: got rdata=%h err=%b cause=%0d cyc=%0d, required rdata=%h err=%b cause=%0d cyc=%0d",
                   ia.resp_rdata, ia.resp_err, ia.resp_cause, cyc,
                   x.rdata, x.err, x.cause, x.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (ib.resp_valid === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL resp_b_unexpected: cause=%0d at cyc %0d, required no response",
                 ib.resp_cause, cyc);
      end else begin
        x = qb.pop_front();
        if (ib.resp_rdata !== x.rdata || ib.resp_err !== x.err ||
            ib.resp_cause !== x.cause || cyc != x.cyc) begin
          errors++;
          $display("FAIL resp_b: got rdata=%h err=%b cause=%0d cyc=%0d, required rdata=%h err=%b cause=%0d cyc=%0d",
                   ib.resp_rdata, ib.resp_err, ib.resp_cause, cyc,
                   x.rdata, x.err, x.cause, x.cyc);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // lat < 0: no response is expected
  task automatic issue(input bit b, input logic w,
                       input logic [1:0] sz, input logic u,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] er, input logic e,
                       input logic [3:0] c, input int lat);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (!(b ? ib.req_ready : ia.req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(n >= 100), 32'd0);
    if (b) begin
      ib.req_we = w; ib.req_size = sz; ib.req_unsigned = u;
      ib.req_addr = ad; ib.req_wdata = wd; ib.req_valid = 1'b1;
    end else begin
      ia.req_we = w; ia.req_size = sz; ia.req_unsigned = u;
      ia.req_addr = ad; ia.req_wdata = wd; ia.req_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if (b) ib.req_valid = 1'b0;
    else   ia.req_valid = 1'b0;
    if (lat >= 0) begin
      x.rdata = er; x.err = e; x.cause = c; x.cyc = cyc + lat;
      if (b) qb.push_back(x);
      else   qa.push_back(x);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= 100), 32'd0);
    @(negedge clk);
    #2;
    rd_cyc = 0; wr_cyc = 0;
  endtask

  initial begin
    int n;
    ia.req_valid = 0; ia.req_we = 0; ia.req_size = 0;
    ia.req_unsigned = 0; ia.req_addr = 0; ia.req_wdata = 0;
    ib.req_valid = 0; ib.req_we = 0; ib.req_size = 0;
    ib.req_unsigned = 0; ib.req_addr = 0; ib.req_wdata = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_a", ia.a, 32'h0);
    chk("rst_rd_we", {30'b0, ia.rd, ia.we}, 32'h0);
    chk("rst_resp", {ia.resp_valid, ia.resp_err, ia.resp_cause, 26'b0}, 32'h0);
    chk("rst_rdata", ia.resp_rdata, 32'h0);
    chk("rst_d", ia.d, 32'h0);
    @(negedge clk) rst = 1'b1;
    #1 chk("ready_after_rst", 32'(ia.req_ready), 32'd1);

    spo_a = 32'h80FF1234;
    issue(0, 0, 2'd0, 0, 32'h103, 0, 32'hFFFFFF80, 0, 0, 1);
    chk("busy_req_ready", 32'(ia.req_ready), 32'd0);
    drain();
    issue(0, 0, 2'd0, 1, 32'h103, 0, 32'h00000080, 0, 0, 1);
    chk("lb_a", rd_a, 32'h100);
    issue(0, 0, 2'd1, 0, 32'h102, 0, 32'hFFFF80FF, 0, 0, 1);
    issue(0, 0, 2'd1, 1, 32'h100, 0, 32'h00001234, 0, 0, 1);
    issue(0, 0, 2'd2, 0, 32'h104, 0, 32'h80FF1234, 0, 0, 1);
    drain();
    chk("loads_rd_cycles", rd_cyc, 32'd0);

    spo_a = 32'h11223344;
    issue(0, 0, 2'd2, 0, 32'h10C, 0, 32'h11223344, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("lw_rd_cycles", rd_cyc, 32'd1);
    chk("lw_a", rd_a, 32'h10C);
    drain();

    issue(0, 1, 2'd1, 0, 32'h102, 32'hABCD, 0, 0, 0, 2);
    drain();
    chk("sh_wr_d", wr_d, 32'hABCD3344);
    chk("sh_wr_a", wr_a, 32'h100);
    issue(0, 1, 2'd0, 0, 32'h101, 32'h55, 0, 0, 0, 2);
    n = 0;
    while (ia.we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    #1 chk("sb_rmw_rd_cycles", rd_cyc, 32'd1);
    drain();
    chk("sb_wr_d", wr_d, 32'h11225544);
    issue(0, 1, 2'd2, 0, 32'h108, 32'hDEADBEEF, 0, 0, 0, 1);
    n = 0;
    while (ia.we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    #1 chk("sw_no_rd", rd_cyc, 32'd0);
    drain();
    chk("sw_wr_d", wr_d, 32'hDEADBEEF);
    chk("sw_wr_a", wr_a, 32'h108);

    issue(0, 1, 2'd2, 0, 32'h101, 32'h1, 0, 1, 4'd6, 0);
    issue(0, 0, 2'd3, 0, 32'h100, 0, 0, 1, 4'd2, 0);
    issue(0, 0, 2'd1, 0, 32'h101, 0, 0, 1, 4'd4, 0);
    issue(0, 1, 2'd3, 0, 32'h101, 0, 0, 1, 4'd2, 0);
    issue(0, 0, 2'd2, 1, 32'h102, 0, 0, 1, 4'd4, 0);
    drain();
    chk("err_no_bus", rd_cyc + wr_cyc, 32'd0);

    rd_wait = 1000;
    issue(0, 0, 2'd2, 0, 32'h100, 0, 0, 1, 4'd5, 4);
    drain();
    chk("tmo_ld_rd_cycles", rd_cyc, 32'd0);
    issue(0, 0, 2'd2, 0, 32'h100, 0, 0, 1, 4'd5, 4);
    n = 0;
    while (qa.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("tmo_ld_rd_hi", rd_cyc, 32'd4);
    chk("tmo_ld_rd_drop", 32'(ia.rd), 32'd0);
    drain();

    rd_wait = 3;
    spo_a = 32'hCAFEF00D;
    issue(0, 0, 2'd2, 0, 32'h100, 0, 32'hCAFEF00D, 0, 0, 4);
    drain();
    rd_wait = 0;
    wr_wait = 1000;
    issue(0, 1, 2'd2, 0, 32'h100, 32'h5, 0, 1, 4'd7, 4);
    n = 0;
    while (qa.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("tmo_st_we_hi", wr_cyc, 32'd4);
    drain();
    rd_wait = 1000;
    issue(0, 1, 2'd0, 0, 32'h100, 32'h5, 0, 1, 4'd7, 4);
    n = 0;
    while (qa.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("tmo_rmw_rd_hi", rd_cyc, 32'd4);
    chk("tmo_rmw_no_wr", wr_cyc, 32'd0);
    drain();

    rd_wait = 0;
    wr_wait = 1000;
    spo_a = 32'h11223344;
    issue(0, 1, 2'd1, 0, 32'h102, 32'hABCD, 0, 0, 0, -1);
    n = 0;
    while (ia.we !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rmw_wr_reached", 32'(ia.we), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_rd_we", {30'b0, ia.rd, ia.we}, 32'h0);
    chk("abort_a", ia.a, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr_wait = 0;
    #1 chk("ready_after_abort", 32'(ia.req_ready), 32'd1);
    spo_a = 32'h0BADF00D;
    issue(0, 0, 2'd2, 0, 32'h104, 0, 32'h0BADF00D, 0, 0, 1);
    drain();

    spo_b = 32'h78563412;
    issue(1, 0, 2'd2, 0, 32'h200, 0, 32'h12345678, 0, 0, 1);
    issue(1, 1, 2'd2, 0, 32'h204, 32'h12345678, 0, 0, 0, 1);
    drain();
    chk("swap_sw_d", wr_d_b, 32'h78563412);
    issue(1, 1, 2'd1, 0, 32'h202, 32'hABCD, 0, 0, 0, 2);
    drain();
    chk("swap_sh_d", wr_d_b, 32'h7856CDAB);
    issue(1, 0, 2'd0, 1, 32'h201, 0, 32'h00000056, 0, 0, 1);
    drain();

    chk("rd_we_exclusive", 32'(both_hi), 32'd0);
    chk("bus_stable", 32'(unstable), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Parametrised load/store unit between the multicycle core's execute stage and the shared a/d/we/rd/spo/ready memory bus.
- Replaces the core's ad-hoc memory phases (MEM, EXU, MEMU, MEM_WAIT).
- Adds configurable data width, optional bus byte-swap, misalignment trapping and bus timeout with access-fault reporting.
- One request in flight at a time; single-cycle response pulse.

Parameters:
- XLEN, 32, data/bus width; legal values 32 or 64.
- BYTE_SWAP, 1, 1 = byte-reverse d/spo lanes on the bus; 0 = pass through.
- TIMEOUT, 0, cycles a bus phase may wait for ready before faulting; 0 = wait forever.
- TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  unit idle, may accept
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when XLEN=64)
- req_unsigned  in  1  zero-extend load
- req_addr  in  32  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  request faulted
- resp_cause  out  4  2 illegal size, 4/6 load/store misaligned, 5/7 load/store access fault
- a  out  32  bus address, aligned to XLEN/8
- d  out  XLEN  bus write data
- we  out  1  bus write
- rd  out  1  bus read
- spo  in  XLEN  bus read data
- ready  in  1  bus completion, sampled at clk edge while rd or we is high

Behaviour:
- Reset (rst low, asynchronous):
  - FSM to IDLE; timeout counter cleared.
  - a=0, d=0, we=0, rd=0, resp_valid=0, resp_err=0, resp_cause=0, resp_rdata=0.
  - req_ready=1 after reset is released.
  - Reset mid-operation aborts immediately: rd/we drop in the same instant, no resp_valid is ever produced for that request.
- Registered outputs: a, d, we, rd and all resp_* are registered. req_ready is combinational: req_ready = (state==IDLE).
- Accept: a request is accepted on a clk edge where req_valid && req_ready. All request fields are latched; inputs are ignored afterwards.
- States: IDLE, RD, WR, RMW_RD, RMW_WR.
- IDLE transitions on accept:
  - Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - Illegal: size 3 when XLEN=32.
  - Misaligned or illegal: stay IDLE, pulse resp_valid with resp_err=1 next cycle, no bus activity. Illegal size takes priority (cause 2).
  - Load: go to RD.
  - Store of full XLEN: go to WR.
  - Store narrower than XLEN: go to RMW_RD.
- RD / RMW_RD:
  - rd=1, a = addr with low log2(XLEN/8) bits cleared.
  - On ready: capture spo (swapped if BYTE_SWAP).
  - RD then goes to IDLE with resp_valid pulse.
  - RMW_RD then goes to RMW_WR.
- Load extraction:
  - Lane = addr offset within the bus word.
  - Size-selected field, sign- or zero-extended to XLEN per req_unsigned.
  - Dword (XLEN=64) is returned unmodified.
- RMW_WR:
  - d = captured word with the addressed lanes replaced by the low bytes of wdata; we=1.
  - On ready: go to IDLE with resp_valid pulse.
- WR: d = wdata (swapped if BYTE_SWAP), we=1. On ready: go to IDLE with resp pulse.
- Latency, zero-wait bus:
  - Load: accept at edge k, rd high in cycle k+1, resp_valid in cycle k+2.
  - Full-width store: resp_valid in cycle k+2.
  - RMW store: resp_valid in cycle k+3.
  - Each wait cycle adds 1.
- Back-to-back: state is IDLE in the resp_valid cycle, so a new request may be accepted in that cycle.
- Timeout (TIMEOUT>0):
  - Counter clears on entering each bus state and increments each cycle ready=0.
  - On reaching TIMEOUT: drop rd/we, go to IDLE, resp_err=1, cause 5 for loads, 7 for stores (including RMW read phase).
  - ready arriving in the same cycle as expiry wins: normal completion.
- rd and we are never high simultaneously.
- a and d remain stable while a bus phase waits.

Test Plan:
- XLEN=32, BYTE_SWAP=0: LB addr 0x103, spo=0x80FF1234, ready=1 -> a=0x100, rd high in one cycle, resp_valid 2 cycles after accept, resp_rdata=0xFFFFFF80. Same with LBU -> 0x00000080.
- SH addr 0x102, wdata=0xABCD, read spo=0x11223344 -> one rd cycle, then we with d=0xABCD3344 at a=0x100; resp_valid 3 cycles after accept, resp_err=0.
- SW addr 0x101 -> no rd/we, resp_valid next cycle, resp_err=1, cause 6. LD (size 3) at XLEN=32 -> cause 2.
- TIMEOUT=4: LW with ready held 0 -> rd high exactly 4 cycles, then rd=0, resp_err=1, cause 5. Repeat with ready rising in the 4th cycle -> normal completion.
- BYTE_SWAP=1: LW addr 0x200, spo=0x78563412 -> 0x12345678. SW wdata 0x12345678 -> d=0x78563412.
- Assert rst low during RMW_WR with ready=0 -> we and rd drop immediately, no resp_valid; after release req_ready=1 and a fresh LW completes normally.
